hit_judge: RTL and testbench

Timing-judgement front end for the rhythm-game solver. Latches a player click as a pending flag, captures the phase and length counters at the click instant, and on request grades the captured phase against a target phase. Output is a signed deviation and a 3-bit verdict. Sits between the input/phase counters and the solver state machine and scorer.

---
 rtl/hit_judge_pkg.sv | 60 ++++++
 rtl/hit_grade_calc.sv | 107 ++++++++++
 rtl/hit_judge.sv | 95 +++++++++
 tb/tb_hit_judge.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hit_judge_pkg.sv
// hit_judge_pkg
//   Shared constants and types for the hit_judge timing-judgement block:
//   phase modulus and grading window defaults, verdict level encodings,
//   the judge FSM state type and the grading helper function.
package hit_judge_pkg;

  // Phase modulus in degrees; phase inputs range 0..PERIOD_DEFAULT-1.
  localparam int PERIOD_DEFAULT      = 360;

  // Grading windows: maximum |dev| for each level.
  localparam int PERFECT_WIN_DEFAULT = 20;
  localparam int GREAT_WIN_DEFAULT   = 45;
  localparam int GOOD_WIN_DEFAULT    = 70;

  // Verdict level encodings (grade[1:0]).
  localparam logic [1:0] LVL_PERFECT = 2'd0;
  localparam logic [1:0] LVL_GREAT   = 2'd1;
  localparam logic [1:0] LVL_GOOD    = 2'd2;
  localparam logic [1:0] LVL_MISS    = 2'd3;

  // Judge FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } judge_state_t;

  // Grade a signed deviation: {late, level}. The magnitude is formed in
  // 17 bits so that -32768 does not overflow when negated.
  function automatic logic [2:0] grade_of(
    input logic signed [15:0] d,
    input int                 perfect_w,
    input int                 great_w,
    input int                 good_w
  );
    logic [16:0] mag_s;
    logic [31:0] mag32_s;
    logic [1:0]  lvl_s;
    logic        late_s;
    if (d[15]) begin
      mag_s = 17'd0 - {d[15], d};
    end else begin
      mag_s = {1'b0, d};
    end
    mag32_s = {15'd0, mag_s};
    if (mag32_s <= $unsigned(perfect_w)) begin
      lvl_s = LVL_PERFECT;
    end else if (mag32_s <= $unsigned(great_w)) begin
      lvl_s = LVL_GREAT;
    end else if (mag32_s <= $unsigned(good_w)) begin
      lvl_s = LVL_GOOD;
    end else begin
      lvl_s = LVL_MISS;
    end
    // Late means strictly positive deviation; zero is on time.
    late_s = ~d[15] & (d != 16'sd0);
    return {late_s, lvl_s};
  endfunction

endpackage

// File: rtl/hit_grade_calc.sv
// hit_grade_calc
//   Judge FSM: on start, latches the captured phase and the target, forms
//   the deviation phase - target, optionally wraps it into
//   [-PERIOD/2, PERIOD/2-1], then grades it and pulses ready.
//   Configuration macro: HIT_JUDGE_WRAP_EN (defined = wrap the deviation
//   modulo PERIOD; undefined = plain 16-bit truncated difference).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle judge request (ignored unless idle)
//   cap_now      captured phase to judge
//   target       target phase
//   ready        one-cycle pulse when dev/grade are valid
//   dev          signed deviation (held until next judgement)
//   grade        {late, level[1:0]} (held until next judgement)
module hit_grade_calc
  import hit_judge_pkg::*;
#(
  parameter int PERIOD      = PERIOD_DEFAULT,
  parameter int PERFECT_WIN = PERFECT_WIN_DEFAULT,
  parameter int GREAT_WIN   = GREAT_WIN_DEFAULT,
  parameter int GOOD_WIN    = GOOD_WIN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        cap_now,
  input  logic [15:0]        target,
  output logic               ready,
  output logic signed [15:0] dev,
  output logic [2:0]         grade
);

  localparam logic signed [16:0] PER_S      = 17'(PERIOD);
  localparam logic signed [16:0] HALF_S     = 17'(PERIOD / 2);
  localparam logic signed [16:0] NEG_HALF_S = 17'(-(PERIOD / 2));

  judge_state_t       state_r;
  logic               calc_step_r;  // CALC spends two cycles: subtract, then wrap
  logic [15:0]        phase_r;
  logic [15:0]        target_r;
  logic signed [16:0] diff_r;
  logic signed [16:0] wrap_s;

  // Fold the raw difference back into the half-open window around zero.
  always_comb begin
    wrap_s = diff_r;
`ifdef HIT_JUDGE_WRAP_EN
    if (diff_r >= HALF_S) begin
      wrap_s = diff_r - PER_S;
    end else if (diff_r < NEG_HALF_S) begin
      wrap_s = diff_r + PER_S;
    end else begin
      wrap_s = diff_r;
    end
`else
    wrap_s = diff_r;
`endif
  end

  // Judge FSM with registered dev, grade and ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      calc_step_r <= 1'b0;
      phase_r     <= 16'd0;
      target_r    <= 16'd0;
      diff_r      <= 17'sd0;
      dev         <= 16'sd0;
      grade       <= 3'd0;
      ready       <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            phase_r     <= cap_now;
            target_r    <= target;
            calc_step_r <= 1'b0;
            state_r     <= ST_CALC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (!calc_step_r) begin
            diff_r      <= $signed({1'b0, phase_r}) - $signed({1'b0, target_r});
            calc_step_r <= 1'b1;
          end else begin
            dev         <= wrap_s[15:0];
            calc_step_r <= 1'b0;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          grade   <= grade_of(dev, PERFECT_WIN, GREAT_WIN, GOOD_WIN);
          ready   <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          calc_step_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/hit_judge.sv
// hit_judge
//   Timing-judgement front end: JK pending flag for player clicks, capture
//   of the phase/length counters at the click, and a judge FSM that grades
//   the captured phase against a target phase.
//   Configuration macro: HIT_JUDGE_WRAP_EN (defined = deviation wrapped
//   modulo PERIOD; undefined = truncated 16-bit difference).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             synchronous clear of cap_now/cap_length
//   hit               click strobe (J input, capture enable)
//   ack               K input of the pending flag
//   now, length       current phase and length counters
//   target            target phase for judging
//   start             one-cycle judge request
//   pending           JK flag
//   cap_now           phase captured at the last hit
//   cap_length        length captured at the last hit
//   ready             one-cycle verdict-valid pulse
//   dev               signed deviation cap_now - target
//   grade             {late, level[1:0]}, level 3 = miss
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int PERIOD      = PERIOD_DEFAULT,
  parameter int PERFECT_WIN = PERFECT_WIN_DEFAULT,
  parameter int GREAT_WIN   = GREAT_WIN_DEFAULT,
  parameter int GOOD_WIN    = GOOD_WIN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               hit,
  input  logic               ack,
  input  logic [15:0]        now,
  input  logic [15:0]        length,
  input  logic [15:0]        target,
  input  logic               start,
  output logic               pending,
  output logic [15:0]        cap_now,
  output logic [15:0]        cap_length,
  output logic               ready,
  output logic signed [15:0] dev,
  output logic [2:0]         grade
);

  // Pending flag as a JK flip-flop: J = hit, K = ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else begin
      case ({hit, ack})
        2'b10:   pending <= 1'b1;
        2'b01:   pending <= 1'b0;
        2'b11:   pending <= ~pending;
        default: pending <= pending;
      endcase
    end
  end

  // Capture registers: clear wins over hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_now    <= 16'd0;
      cap_length <= 16'd0;
    end else if (clear) begin
      cap_now    <= 16'd0;
      cap_length <= 16'd0;
    end else if (hit) begin
      cap_now    <= now;
      cap_length <= length;
    end else begin
      cap_now    <= cap_now;
      cap_length <= cap_length;
    end
  end

  // The judge latches the registered cap_now, so a hit in the same cycle
  // as start is not part of that judgement.
  hit_grade_calc #(
    .PERIOD      (PERIOD),
    .PERFECT_WIN (PERFECT_WIN),
    .GREAT_WIN   (GREAT_WIN),
    .GOOD_WIN    (GOOD_WIN)
  ) u_calc (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cap_now (cap_now),
    .target  (target),
    .ready   (ready),
    .dev     (dev),
    .grade   (grade)
  );

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               hit;
  logic               ack;
  logic [15:0]        now;
  logic [15:0]        length;
  logic [15:0]        target;
  logic               start;
  logic               pending;
  logic [15:0]        cap_now;
  logic [15:0]        cap_length;
  logic               ready;
  logic signed [15:0] dev;
  logic [2:0]         grade;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];

  hit_judge dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .hit        (hit),
    .ack        (ack),
    .now        (now),
    .length     (length),
    .target     (target),
    .start      (start),
    .pending    (pending),
    .cap_now    (cap_now),
    .cap_length (cap_length),
    .ready      (ready),
    .dev        (dev),
    .grade      (grade)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hit(input logic [15:0] v, input logic [15:0] l);
    now = v;
    length = l;
    hit = 1'b1;
    step();
    hit = 1'b0;
  endtask

  // Issue a judgement of the currently captured phase against tg.
  // poke re-pulses start while the FSM is busy; with_hit clicks in the
  // same cycle as start (that click must not be judged).
  task automatic judge(input string name, input logic [15:0] tg,
                       input logic signed [15:0] edev, input logic [2:0] egr,
                       input logic poke, input logic with_hit, input logic [15:0] hit_now);
    target = tg;
    start = 1'b1;
    hit = with_hit;
    now = hit_now;
    exp_q.push_back({edev, egr});
    step();                       // edge N
    start = 1'b0;
    hit = 1'b0;
    if (poke) begin
      start = 1'b1;
      target = 16'd0;
    end
    step();                       // edge N+1
    start = 1'b0;
    chk({name, "_ready_n1"}, {31'd0, ready}, 32'd0);
    step();                       // edge N+2
    chk({name, "_dev_n2"}, {16'd0, dev}, {16'd0, edev});
    chk({name, "_ready_n2"}, {31'd0, ready}, 32'd0);
    step();                       // edge N+3
    chk({name, "_ready_n3"}, {31'd0, ready}, 32'd1);
    step();                       // edge N+4
    chk({name, "_ready_n4"}, {31'd0, ready}, 32'd0);
  endtask

  // Scoreboard monitor: every ready pulse pops one expected verdict.
  always @(negedge clk) begin
    if (!rst && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready actual dev=%0d grade=%b required no pulse", dev, grade);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({dev, grade} !== e) begin
          errors++;
          $display("FAIL verdict actual dev=%0d grade=%b required dev=%0d grade=%b",
                   dev, grade, $signed(e[18:3]), e[2:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; hit = 1'b0; ack = 1'b0; start = 1'b0;
    now = 16'd0; length = 16'd0; target = 16'd0;
    step(); step(); step();
    chk("rst_pending", {31'd0, pending}, 32'd0);
    chk("rst_cap_now", {16'd0, cap_now}, 32'd0);
    chk("rst_cap_length", {16'd0, cap_length}, 32'd0);
    chk("rst_dev", {16'd0, dev}, 32'd0);
    chk("rst_grade", {29'd0, grade}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    step();

    // Pending flag and capture.
    do_hit(16'd100, 16'd500);
    chk("hit_cap_now", {16'd0, cap_now}, 32'd100);
    chk("hit_cap_length", {16'd0, cap_length}, 32'd500);
    chk("hit_pending", {31'd0, pending}, 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("ack_pending", {31'd0, pending}, 32'd0);
    chk("ack_cap_hold", {16'd0, cap_now}, 32'd100);
    ack = 1'b1; do_hit(16'd100, 16'd500); ack = 1'b0;
    chk("toggle_pending", {31'd0, pending}, 32'd1);
    step();
    chk("hold_pending", {31'd0, pending}, 32'd1);

    // Judgements.
    judge("j100_90", 16'd90, 16'sd10, 3'b100, 1'b1, 1'b0, 16'd0);
    do_hit(16'd10, 16'd1);
`ifdef HIT_JUDGE_WRAP_EN
    judge("j10_350", 16'd350, 16'sd20, 3'b100, 1'b0, 1'b0, 16'd0);
    do_hit(16'd300, 16'd2);
    judge("j300_0", 16'd0, -16'sd60, 3'b010, 1'b0, 1'b0, 16'd0);
    do_hit(16'd200, 16'd3);
    judge("j200_0", 16'd0, -16'sd160, 3'b011, 1'b0, 1'b0, 16'd0);
    do_hit(16'd180, 16'd4);
    judge("j180_0", 16'd0, -16'sd180, 3'b011, 1'b0, 1'b0, 16'd0);
    do_hit(16'd0, 16'd5);
    judge("j0_181", 16'd181, 16'sd179, 3'b111, 1'b0, 1'b0, 16'd0);
`else
    judge("j10_350", 16'd350, -16'sd340, 3'b011, 1'b0, 1'b0, 16'd0);
    do_hit(16'd300, 16'd2);
    judge("j300_0", 16'd0, 16'sd300, 3'b111, 1'b0, 1'b0, 16'd0);
    do_hit(16'd200, 16'd3);
    judge("j200_0", 16'd0, 16'sd200, 3'b111, 1'b0, 1'b0, 16'd0);
    do_hit(16'd180, 16'd4);
    judge("j180_0", 16'd0, 16'sd180, 3'b111, 1'b0, 1'b0, 16'd0);
    do_hit(16'd0, 16'd5);
    judge("j0_181", 16'd181, -16'sd181, 3'b011, 1'b0, 1'b0, 16'd0);
`endif
    judge("j0_179", 16'd179, -16'sd179, 3'b011, 1'b0, 1'b0, 16'd0);
    judge("j0_70", 16'd70, -16'sd70, 3'b010, 1'b0, 1'b0, 16'd0);
    judge("j0_0", 16'd0, 16'sd0, 3'b000, 1'b0, 1'b0, 16'd0);
    do_hit(16'd20, 16'd6);
    judge("j20_0", 16'd0, 16'sd20, 3'b100, 1'b0, 1'b0, 16'd0);
    do_hit(16'd21, 16'd7);
    judge("j21_0", 16'd0, 16'sd21, 3'b101, 1'b0, 1'b0, 16'd0);
    do_hit(16'd45, 16'd8);
    judge("j45_0", 16'd0, 16'sd45, 3'b101, 1'b0, 1'b0, 16'd0);
    do_hit(16'd46, 16'd9);
    judge("j46_0", 16'd0, 16'sd46, 3'b110, 1'b0, 1'b0, 16'd0);
    do_hit(16'd71, 16'd10);
    judge("j71_0", 16'd0, 16'sd71, 3'b111, 1'b0, 1'b0, 16'd0);

    // A click in the start cycle is captured but not judged.
    do_hit(16'd100, 16'd11);
    judge("same_cycle_hit", 16'd90, 16'sd10, 3'b100, 1'b0, 1'b1, 16'd50);
    chk("same_cycle_cap", {16'd0, cap_now}, 32'd50);

    // Clear has priority over hit.
    do_hit(16'd100, 16'd12);
    clear = 1'b1; now = 16'd77; length = 16'd88; hit = 1'b1;
    step();
    clear = 1'b0; hit = 1'b0;
    chk("clear_cap_now", {16'd0, cap_now}, 32'd0);
    chk("clear_cap_length", {16'd0, cap_length}, 32'd0);

    // Reset during CALC aborts the judgement.
    do_hit(16'd100, 16'd13);
    target = 16'd90; start = 1'b1;
    step();
    start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_ready", {31'd0, ready}, 32'd0);
      step();
    end
    chk("abort_dev", {16'd0, dev}, 32'd0);
    chk("abort_grade", {29'd0, grade}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
